// File: rtl/gt_vortex_pkg.sv
// Shared definitions for the Vortex APB control block: register map, bit
// positions and controller state encoding.
package gt_vortex_pkg;

    localparam int unsigned APB_AW  = 32;
    localparam int unsigned APB_DW  = 32;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned STATE_W = 3;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_CYCLES = 8'h08;

    localparam int unsigned CTRL_START_BIT   = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 1;
    localparam int unsigned STAT_BUSY_BIT    = 0;
    localparam int unsigned STAT_DONE_BIT    = 1;
    localparam int unsigned STAT_TIMEOUT_BIT = 2;
    localparam int unsigned STAT_STATE_LSB   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RUN  = 3'd3
    } state_t;

endpackage

// File: rtl/gt_vortex_apb_ctrl.sv
// APB control/status block that sequences reset and start-up of the Vortex
// AXI wrapper and reports completion or start timeout.
// Optional cycle counter: define GT_VORTEX_CSR_PERF_EN.
module gt_vortex_apb_ctrl
    import gt_vortex_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned START_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [APB_AW-1:0] paddr,
    input  logic [APB_DW-1:0] pwdata,
    output logic [APB_DW-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              vx_reset,
    input  logic              busy,
    output logic              irq
);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cycles_rd;
    logic              busy_q;
    logic              irq_en;
    logic              done;
    logic              timeout;
    logic              done_set;
    logic              timeout_set;
    logic [APB_DW-1:0] rdata;

    logic       access;
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic       addr_hit;
    logic       start_req;
    logic       err;
    logic       wr_ok;
    logic       start_go;
    logic       ctrl_wr;
    logic       stat_wr;
    logic       unused_bits;

    // APB decode; an errored write commits nothing
    assign access    = psel & penable;
    assign wr        = access & pwrite;
    assign rd        = access & ~pwrite;
    assign addr      = paddr[7:0];
    assign addr_hit  = (addr == ADDR_CTRL) | (addr == ADDR_STATUS) | (addr == ADDR_CYCLES);
    assign start_req = wr & (addr == ADDR_CTRL) & pwdata[CTRL_START_BIT];
    assign err       = ~addr_hit | (start_req & (state != ST_IDLE));
    assign wr_ok     = wr & ~err;
    assign start_go  = wr_ok & start_req;
    assign ctrl_wr   = wr_ok & (addr == ADDR_CTRL);
    assign stat_wr   = wr_ok & (addr == ADDR_STATUS);

    assign unused_bits = ^{paddr[APB_AW-1:8], pwdata[APB_DW-1:3]};

    // Zero-wait-state response, held quiet while reset is asserted
    assign pready  = access & ~reset;
    assign pslverr = access & err & ~reset;
    assign prdata  = (rd & ~reset) ? rdata : '0;

    assign vx_reset = (state == ST_IDLE) | (state == ST_RST);
    assign irq      = irq_en & (done | timeout);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic and sticky-flag set strobes
    always_comb begin
        state_next  = state;
        done_set    = 1'b0;
        timeout_set = 1'b0;
        case (state)
            ST_IDLE: if (start_go) state_next = ST_RST;
            ST_RST:  if (cnt == CNT_W'(RESET_CYCLES - 1)) state_next = ST_WAIT;
            ST_WAIT: begin
                if (busy_q) begin
                    state_next = ST_RUN;
                end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            // RUN is only entered with busy_q high, so a low sample here is a falling edge
            ST_RUN: begin
                if (!busy_q) begin
                    done_set   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Per-state dwell counter, restarted on every state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    cnt <= '0;
        else if (state_next != state) cnt <= '0;
        else                          cnt <= cnt + CNT_W'(1);
    end

    // Busy synchroniser stage and control/status registers; set beats W1C
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            irq_en  <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            busy_q  <= busy;
            if (ctrl_wr) irq_en <= pwdata[CTRL_IRQ_EN_BIT];
            done    <= done_set    | (done    & ~(stat_wr & pwdata[STAT_DONE_BIT]));
            timeout <= timeout_set | (timeout & ~(stat_wr & pwdata[STAT_TIMEOUT_BIT]));
        end
    end

`ifdef GT_VORTEX_CSR_PERF_EN
    logic [CNT_W-1:0] cycles;

    // Saturating run-length counter over WAIT and RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles <= '0;
        end else if (start_go) begin
            cycles <= '0;
        end else if (((state == ST_WAIT) || (state == ST_RUN)) && (cycles != '1)) begin
            cycles <= cycles + CNT_W'(1);
        end
    end

    assign cycles_rd = cycles;
`else
    assign cycles_rd = '0;
`endif

    // Register read mux
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata[CTRL_IRQ_EN_BIT] = irq_en;
            ADDR_STATUS: begin
                rdata[STAT_BUSY_BIT]                    = busy_q;
                rdata[STAT_DONE_BIT]                    = done;
                rdata[STAT_TIMEOUT_BIT]                 = timeout;
                rdata[STAT_STATE_LSB +: STATE_W]        = state;
            end
            ADDR_CYCLES: rdata = cycles_rd;
            default:     rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_gt_vortex_apb_ctrl.sv
// Directed bench for gt_vortex_apb_ctrl with default parameters.
module tb_gt_vortex_apb_ctrl;

    logic        clk;
    logic        reset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        vx_reset;
    logic        busy;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] r;
    logic        e;
    logic        rdy;

    gt_vortex_apb_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .vx_reset (vx_reset),
        .busy     (busy),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One APB transfer; response sampled mid access phase, commit on following posedge
    task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rv, output logic ev, output logic rdyv);
        @(negedge clk);
        psel = 1'b1; pwrite = w; paddr = a; pwdata = d; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rv = prdata; ev = pslverr; rdyv = pready;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; busy = 1'b0;
        #1;
        check("rst_vx_reset", 32'(vx_reset), 32'd1);
        check("rst_irq",      32'(irq),      32'd0);
        check("rst_pready",   32'(pready),   32'd0);
        check("rst_prdata",   prdata,        32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle read and bus-idle outputs
        apb(1'b0, 32'h04, 32'h0, r, e, rdy);
        check("idle_status", r, 32'h0);
        check("idle_rdy",    32'(rdy), 32'd1);
        check("idle_err",    32'(e),   32'd0);
        #2;
        check("bus_idle_pready", 32'(pready), 32'd0);

        // START with IRQ_EN: vx_reset held through exactly 16 RST cycles
        apb(1'b1, 32'h00, 32'h3, r, e, rdy);
        check("start_err", 32'(e), 32'd0);
        repeat (15) @(posedge clk);
        #1;
        check("rst_cycle16_vx_reset", 32'(vx_reset), 32'd1);
        @(posedge clk);
        #1;
        check("rst_release_vx_reset", 32'(vx_reset), 32'd0);

        apb(1'b0, 32'h00, 32'h0, r, e, rdy);
        check("ctrl_read", r, 32'h2);

        // busy high -> RUN; errored accesses during RUN
        busy = 1'b1;
        repeat (5) @(posedge clk);
        apb(1'b0, 32'h04, 32'h0, r, e, rdy);
        check("run_status", r, 32'h19);
        apb(1'b1, 32'h00, 32'h3, r, e, rdy);
        check("run_start_err", 32'(e),   32'd1);
        check("run_start_rdy", 32'(rdy), 32'd1);
        apb(1'b0, 32'h10, 32'h0, r, e, rdy);
        check("unmapped_err",    32'(e),   32'd1);
        check("unmapped_rdy",    32'(rdy), 32'd1);
        check("unmapped_prdata", r,        32'd0);
        apb(1'b0, 32'h04, 32'h0, r, e, rdy);
        check("run_status_after_err", r, 32'h19);
        repeat (90) @(posedge clk);
        #1;
        busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_irq", 32'(irq), 32'd1);
        apb(1'b0, 32'h04, 32'h0, r, e, rdy);
        check("done_status", r, 32'h2);
        apb(1'b0, 32'h08, 32'h0, r, e, rdy);
        check("cycles_err", 32'(e), 32'd0);
`ifdef GT_VORTEX_CSR_PERF_EN
        check("cycles_min", 32'(r >= 32'd101), 32'd1);
`else
        check("cycles_zero", r, 32'd0);
`endif

        // W1C of DONE
        apb(1'b1, 32'h04, 32'h2, r, e, rdy);
        apb(1'b0, 32'h04, 32'h0, r, e, rdy);
        check("w1c_status", r, 32'h0);
        check("w1c_irq", 32'(irq), 32'd0);

        // Timeout: WAIT lasts 1024 cycles after the 16 RST cycles
        apb(1'b1, 32'h00, 32'h3, r, e, rdy);
        repeat (1039) @(posedge clk);
        #1;
        check("wait_last_vx_reset", 32'(vx_reset), 32'd0);
        @(posedge clk);
        #1;
        check("timeout_vx_reset", 32'(vx_reset), 32'd1);
        check("timeout_irq",      32'(irq),      32'd1);
        apb(1'b0, 32'h04, 32'h0, r, e, rdy);
        check("timeout_status", r, 32'h4);
        apb(1'b1, 32'h04, 32'h4, r, e, rdy);
        apb(1'b0, 32'h04, 32'h0, r, e, rdy);
        check("timeout_clear", r, 32'h0);

        // W1C of DONE on the same edge DONE is set
        apb(1'b1, 32'h00, 32'h3, r, e, rdy);
        repeat (20) @(posedge clk);
        #1;
        busy = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        busy = 1'b0;
        psel = 1'b1; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h2; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        check("race_rdy", 32'(pready),  32'd1);
        check("race_err", 32'(pslverr), 32'd0);
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        apb(1'b0, 32'h04, 32'h0, r, e, rdy);
        check("race_done_kept", r, 32'h2);

        // Async reset mid-RUN with a read in its access phase
        apb(1'b1, 32'h00, 32'h3, r, e, rdy);
        repeat (20) @(posedge clk);
        #1;
        busy = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h04;
        #1;
        check("pre_reset_status", prdata, 32'h1B);
        check("pre_reset_irq", 32'(irq), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("midrun_vx_reset", 32'(vx_reset), 32'd1);
        check("midrun_irq",      32'(irq),      32'd0);
        check("midrun_pready",   32'(pready),   32'd0);
        check("midrun_prdata",   prdata,        32'd0);
        check("midrun_pslverr",  32'(pslverr),  32'd0);
        psel = 1'b0; penable = 1'b0; busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        apb(1'b0, 32'h04, 32'h0, r, e, rdy);
        check("post_reset_status", r, 32'h0);
        apb(1'b0, 32'h00, 32'h0, r, e, rdy);
        check("post_reset_ctrl", r, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gt_vortex_apb_ctrl.md
GT_VORTEX_APB_CTRL -- requirements
Module: gt_vortex_apb_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16, meaning cycles vx_reset is held high after a start command (legal range 1..255).
REQ-002 SHALL have parameter START_TIMEOUT, default 1024, meaning maximum cycles to wait for busy to rise after vx_reset is released.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports psel, penable, pwrite, inputs, 1 bit each: APB control.
REQ-006 SHALL have ports paddr and pwdata, inputs, 32 bits each: APB address and write data.
REQ-007 SHALL have port prdata, output, 32 bits: APB read data.
REQ-008 SHALL have ports pready and pslverr, outputs, 1 bit each: APB completion and error.
REQ-009 SHALL have port vx_reset, output, 1 bit: reset to the Vortex AXI wrapper.
REQ-010 SHALL have port busy, input, 1 bit: busy from the Vortex AXI wrapper.
REQ-011 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-012 SHALL decode paddr[7:0] only: 0x00 CTRL, 0x04 STATUS, 0x08 CYCLES.
- CTRL: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN (R/W).
- STATUS: bit0 busy (RO); bit1 DONE (sticky, W1C); bit2 TIMEOUT (sticky, W1C); bits[5:3] FSM state (RO).
REQ-013 SHALL complete every access with zero wait states: pready=1 whenever psel&penable, else 0.
REQ-014 SHALL commit writes on the clk edge ending the access phase (psel&penable&pwrite).
REQ-015 SHALL drive prdata combinationally from the registers when psel&penable&!pwrite, else 0.
REQ-016 SHALL assert pslverr with pready for an unmapped address.
REQ-017 SHALL assert pslverr with pready for a START write outside IDLE; that command is ignored.
REQ-018 SHALL implement the FSM IDLE -> RST -> WAIT -> RUN -> IDLE.
- IDLE: vx_reset=1; a START write moves to RST.
- RST: vx_reset=1 for exactly RESET_CYCLES cycles, then WAIT.
- WAIT: vx_reset=0; busy=1 moves to RUN; START_TIMEOUT cycles without busy sets TIMEOUT and returns to IDLE.
- RUN: vx_reset=0; busy falling (sampled 1 then 0) sets DONE and returns to IDLE.
REQ-019 SHALL make irq = IRQ_EN & (DONE | TIMEOUT).
REQ-020 SHALL give set priority over a same-cycle W1C clear of DONE or TIMEOUT.
REQ-021 SHALL register busy once before use; busy sampled in IDLE or RST SHALL be ignored.

Reset
REQ-022 SHALL on reset assertion, at any time including mid-run, immediately force FSM=IDLE, vx_reset=1, IRQ_EN=0, DONE=0, TIMEOUT=0, CYCLES=0, irq=0, pslverr=0, pready=0, prdata=0.

Configuration
REQ-023 SHALL gate the cycle counter with macro GT_VORTEX_CSR_PERF_EN.
- Defined: CYCLES is a 32-bit counter, cleared on entry to RST, incremented each cycle in WAIT and RUN, saturating at 0xFFFFFFFF.
- Undefined: CYCLES reads 0, no counter logic exists, and the address stays mapped (no pslverr).

Structure
REQ-024 SHALL place register offsets, bit positions and the FSM state enum in the shared package gt_vortex_pkg.
REQ-025 SHALL keep the APB decode inline and instantiate no sub-modules.

Verification
REQ-026 SHALL cover these directed scenarios:
- Write CTRL=0x3 with RESET_CYCLES=16 -> vx_reset high exactly 16 cycles, then low.
- busy rises, holds 100 cycles, then falls -> STATUS=0x2 and irq=1; CYCLES=101 or more with PERF_EN.
- busy never rises -> TIMEOUT set after 1024 cycles, STATUS bit2=1, FSM=IDLE, vx_reset=1.
- START write during RUN, and read of 0x10 -> pslverr=1 with pready, FSM unchanged.
- W1C to DONE in the same cycle busy falls -> DONE stays 1.
- reset asserted mid-RUN -> vx_reset=1 and all status bits 0 without a clock edge.
